cache_2b: RTL and testbench

Two-way set-associative, write-back, write-allocate data cache with LRU replacement, bundled with its 1 KiB byte-addressed main memory. It sits between a word-oriented load/store requester and main memory. It accepts one read or write request per clock and reports hit/miss together with the read word.

---
 rtl/cache2b_pkg.sv | 36 +++
 rtl/main_mem.sv | 31 +++
 rtl/cache_2b.sv | 109 ++++++++++
 tb/tb_cache_2b.sv | 124 ++++++++++++
 4 files changed

// File: rtl/cache2b_pkg.sv
// rtl/cache2b_pkg.sv - geometry constants, address-field helpers and line type for cache_2b
package cache2b_pkg;

    localparam int ADDR_W          = 10;
    localparam int DATA_W          = 32;
    localparam int WORDS_PER_BLOCK = 4;
    localparam int NUM_SETS        = 2;
    localparam int NUM_WAYS        = 2;
    localparam int TAG_W           = 5;
    localparam int SET_W           = 1;
    localparam int WORD_W          = 2;
    localparam int BLOCK_W         = DATA_W * WORDS_PER_BLOCK;
    localparam int BLK_ADDR_W      = TAG_W + SET_W;

    typedef logic [WORDS_PER_BLOCK-1:0][DATA_W-1:0] block_t;

    typedef struct packed {
        logic             valid;
        logic             dirty;
        logic [TAG_W-1:0] tag;
        block_t           data;
    } line_t;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
        return a[9:5];
    endfunction

    function automatic logic [SET_W-1:0] addr_set(input logic [ADDR_W-1:0] a);
        return a[4];
    endfunction

    function automatic logic [WORD_W-1:0] addr_word(input logic [ADDR_W-1:0] a);
        return a[3:2];
    endfunction

endpackage

// File: rtl/main_mem.sv
// rtl/main_mem.sv - 1 KiB byte-wide main memory with combinational block read, synchronous block write
module main_mem
    import cache2b_pkg::*;
(
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [BLK_ADDR_W-1:0] waddr_i,
    input  logic [BLOCK_W-1:0]    wdata_i,
    input  logic [BLK_ADDR_W-1:0] raddr_i,
    output logic [BLOCK_W-1:0]    rdata_o
);

    reg [7:0] memory [0:1023];

    // Byte i of a block lives at block_base + i (little-endian words).
    always_comb begin
        rdata_o = '0;
        for (int i = 0; i < 16; i++) begin
            rdata_o[8*i +: 8] = memory[{raddr_i, 4'(i)}];
        end
    end

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int i = 0; i < 16; i++) begin
                memory[{waddr_i, 4'(i)}] <= wdata_i[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/cache_2b.sv
// rtl/cache_2b.sv - two-way set-associative write-back cache with LRU and bundled main memory
module cache_2b
    import cache2b_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              read_write,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
    output logic              hit
);

    line_t               lines_q [NUM_SETS][NUM_WAYS];
    line_t               lines_d [NUM_SETS][NUM_WAYS];
    logic [NUM_SETS-1:0] lru_q, lru_d;
    logic [DATA_W-1:0]   read_data_q, read_data_d;
    logic                hit_q, hit_d;

    logic [TAG_W-1:0]      req_tag;
    logic [SET_W-1:0]      req_set;
    logic [WORD_W-1:0]     req_word;
    logic                  hit0, hit1, lookup_hit;
    logic                  way;
    line_t                 cur_line, new_line;
    logic                  mem_we;
    logic [BLK_ADDR_W-1:0] mem_waddr, mem_raddr;
    logic [BLOCK_W-1:0]    mem_wdata, mem_rdata;
    logic                  unused_byte_bits;

    assign unused_byte_bits = ^address[1:0];

    assign req_tag  = addr_tag(address);
    assign req_set  = addr_set(address);
    assign req_word = addr_word(address);

    always_comb begin
        lines_d     = lines_q;
        lru_d       = lru_q;
        read_data_d = read_data_q;

        hit0       = lines_q[req_set][0].valid && (lines_q[req_set][0].tag == req_tag);
        hit1       = lines_q[req_set][1].valid && (lines_q[req_set][1].tag == req_tag);
        lookup_hit = hit0 || hit1;
        hit_d      = lookup_hit;

        // Victim: first invalid way, otherwise the LRU way.
        if (lookup_hit)                        way = hit1 && !hit0;
        else if (!lines_q[req_set][0].valid)   way = 1'b0;
        else if (!lines_q[req_set][1].valid)   way = 1'b1;
        else                                   way = lru_q[req_set];

        cur_line  = lines_q[req_set][way];
        mem_we    = !lookup_hit && cur_line.valid && cur_line.dirty;
        mem_waddr = {cur_line.tag, req_set};
        mem_wdata = cur_line.data;
        mem_raddr = {req_tag, req_set};

        new_line = cur_line;
        if (!lookup_hit) begin
            new_line.valid = 1'b1;
            new_line.dirty = 1'b0;
            new_line.tag   = req_tag;
            new_line.data  = mem_rdata;
        end

        if (read_write) begin
            new_line.data[req_word] = write_data;
            new_line.dirty          = 1'b1;
        end else begin
            read_data_d = new_line.data[req_word];
        end

        lines_d[req_set][way] = new_line;
        lru_d[req_set]        = ~way;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    lines_q[s][w] <= '0;
                end
            end
            lru_q       <= '0;
            read_data_q <= '0;
            hit_q       <= 1'b0;
        end else begin
            lines_q     <= lines_d;
            lru_q       <= lru_d;
            read_data_q <= read_data_d;
            hit_q       <= hit_d;
        end
    end

    // The victim write-back happens on the same edge as the refill read; they never alias.
    main_mem mem (
        .clk     (clk),
        .we_i    (mem_we && !rst),
        .waddr_i (mem_waddr),
        .wdata_i (mem_wdata),
        .raddr_i (mem_raddr),
        .rdata_o (mem_rdata)
    );

    assign read_data = read_data_q;
    assign hit       = hit_q;

endmodule

// File: tb/tb_cache_2b.sv
// tb/tb_cache_2b.sv - directed self-checking bench for cache_2b
module tb_cache_2b;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        read_write = 1'b0;
    logic [9:0]  address = '0;
    logic [31:0] write_data = '0;
    logic [31:0] read_data;
    logic        hit;

    int n_checks = 0;
    int n_pass   = 0;

    cache_2b dut (
        .clk        (clk),
        .rst        (rst),
        .read_write (read_write),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .hit        (hit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic req(input logic rw, input logic [9:0] a, input logic [31:0] d);
        read_write = rw;
        address    = a;
        write_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_mem(input string tag, input int a, input logic [7:0] exp);
        chk(tag, {24'h0, dut.mem.memory[a]}, {24'h0, exp});
    endtask

    initial begin
        rst = 1'b1;
        req(1'b0, 10'h000, 32'h0);
        chk("reset_hit", {31'h0, hit}, 32'd0);
        chk("reset_rdata", read_data, 32'h0);
        rst = 1'b0;

        req(1'b0, 10'h000, 32'h0);
        chk("t1_hit", {31'h0, hit}, 32'd0);
        chk("t1_rdata", read_data, 32'h0);

        req(1'b1, 10'h000, 32'h000000FF);
        chk("t2_hit", {31'h0, hit}, 32'd1);
        chk("t2_rdata_held", read_data, 32'h0);

        req(1'b0, 10'h000, 32'h0);
        chk("t3_hit", {31'h0, hit}, 32'd1);
        chk("t3_rdata", read_data, 32'h000000FF);
        for (int i = 0; i < 4; i++) chk_mem("t3_mem_untouched", i, 8'h00);

        req(1'b0, 10'h200, 32'h0);
        chk("t4_miss", {31'h0, hit}, 32'd0);
        chk("t4_rdata", read_data, 32'h0);
        req(1'b0, 10'h000, 32'h0);
        chk("t4_both_kept", {31'h0, hit}, 32'd1);
        chk("t4_rdata2", read_data, 32'h000000FF);

        req(1'b0, 10'h300, 32'h0);
        chk("t5_miss300", {31'h0, hit}, 32'd0);
        req(1'b0, 10'h200, 32'h0);
        chk("t5_miss200", {31'h0, hit}, 32'd0);
        chk_mem("t5_wb_b0", 0, 8'hFF);
        for (int i = 1; i < 4; i++) chk_mem("t5_wb_bn", i, 8'h00);
        req(1'b0, 10'h000, 32'h0);
        chk("t5_refill_miss", {31'h0, hit}, 32'd0);
        chk("t5_refill_rdata", read_data, 32'h000000FF);
        req(1'b0, 10'h200, 32'h0);
        chk("t5_200_hit", {31'h0, hit}, 32'd1);

        req(1'b1, 10'h010, 32'hDEADBEEF);
        chk("t6_set1_miss", {31'h0, hit}, 32'd0);
        req(1'b0, 10'h013, 32'h0);
        chk("t6_wr_rd_hit", {31'h0, hit}, 32'd1);
        chk("t6_wr_rd_data", read_data, 32'hDEADBEEF);
        req(1'b0, 10'h000, 32'h0);
        chk("t6_set0_kept", {31'h0, hit}, 32'd1);
        req(1'b0, 10'h200, 32'h0);
        chk("t6_set0_kept2", {31'h0, hit}, 32'd1);
        chk_mem("t6_mem10", 16'h10, 8'h00);

        rst = 1'b1;
        req(1'b0, 10'h010, 32'h0);
        chk("t6_rst_hit", {31'h0, hit}, 32'd0);
        chk("t6_rst_rdata", read_data, 32'h0);
        rst = 1'b0;
        req(1'b0, 10'h010, 32'h0);
        chk("t6_post_rst_miss", {31'h0, hit}, 32'd0);
        chk("t6_post_rst_data", read_data, 32'h0);
        req(1'b0, 10'h010, 32'h0);
        chk("t6_repeat_hit", {31'h0, hit}, 32'd1);

        req(1'b1, 10'h024, 32'h11223344);
        chk("le_wr_miss", {31'h0, hit}, 32'd0);
        req(1'b0, 10'h220, 32'h0);
        chk("le_fill_w1", {31'h0, hit}, 32'd0);
        req(1'b0, 10'h320, 32'h0);
        chk("le_evict", {31'h0, hit}, 32'd0);
        chk_mem("le_b0", 16'h24, 8'h44);
        chk_mem("le_b1", 16'h25, 8'h33);
        chk_mem("le_b2", 16'h26, 8'h22);
        chk_mem("le_b3", 16'h27, 8'h11);
        req(1'b0, 10'h024, 32'h0);
        chk("le_reload_miss", {31'h0, hit}, 32'd0);
        chk("le_reload_data", read_data, 32'h11223344);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
